// File: rtl/comparator_bist.sv
// Exhaustive built-in self test for an external magnitude comparator.
// The block walks every (a, b) operand pair in ascending order, holds each
// pair for SETTLE cycles, and then samples the comparator's l/e/g response.
// It counts mismatching vectors (saturating) and captures the first failing
// pair. fsm_state exposes the controller state for observation.
//
// Handshake: start is a level sampled on the rising edge. It is accepted only
// outside RUN (IDLE or DONE). busy is high for the whole run. done stays high
// from completion until the next accepted start, and pass/err_count/fail_a/
// fail_b are stable and valid while done is high.
module comparator_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  input  logic                 l,
  input  logic                 e,
  input  logic                 g,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic [1:0]           fsm_state
);

  localparam int IW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};
  localparam logic [EW-1:0] ERR_MAX = {EW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IW-1:0]    idx;
  logic [3:0]       settle_cnt;
  logic             first_seen;
  logic             accept;
  logic             sample;
  logic             mismatch;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       exp_resp;
  logic [2:0]       got_resp;

  // The vector index splits into the two operands; b is the low half so it
  // advances fastest.
  assign op_a = idx[IW-1:WIDTH];
  assign op_b = idx[WIDTH-1:0];

  // Start is honoured only when no run is in flight.
  assign accept = start && (state_q != RUN);

  // The response is sampled on the edge that closes the last settle cycle.
  assign sample = (state_q == RUN) && (settle_cnt == SETTLE_LAST);

  // Golden one-hot response and mismatch detection for the current vector.
  always_comb begin
    exp_resp = {(op_a < op_b), (op_a == op_b), (op_a > op_b)};
    got_resp = {l, e, g};
    mismatch = sample && (got_resp != exp_resp);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: runs start from IDLE or DONE, end after the last sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (sample && (idx == IDX_LAST)) state_d = DONE;
      DONE: if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: operands are driven only while running, pass only in DONE.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    a         = '0;
    b         = '0;
    fsm_state = state_q;
    case (state_q)
      RUN: begin
        busy = 1'b1;
        a    = op_a;
        b    = op_b;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    pass = done && (err_count == '0);
  end

  // Vector sequencing, error counting and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      first_seen <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else if (accept) begin
      idx        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      first_seen <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else if (state_q == RUN) begin
      if (sample) begin
        settle_cnt <= '0;
        idx        <= idx + 1'b1;
        if (mismatch) begin
          if (err_count != ERR_MAX) begin
            err_count <= err_count + 1'b1;
          end
          if (!first_seen) begin
            first_seen <= 1'b1;
            fail_a     <= op_a;
            fail_b     <= op_b;
          end
        end
      end else begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comparator_bist.sv
// Testbench for comparator_bist: a behavioural comparator (optionally faulty)
// answers the BIST, and a reference model predicts run length, operand
// sequence, error count and first failing vector.
module tb_comparator_bist;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 2;
  localparam int NVEC   = 1 << (2 * WIDTH);
  localparam int RUN_CYCLES = NVEC * SETTLE;

  // Fault modes of the comparator model.
  localparam int M_GOOD    = 0;
  localparam int M_E_STUCK = 1;
  localparam int M_LG_SWAP = 2;
  localparam int M_ALL_ONE = 3;
  localparam int M_RANDOM  = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             l;
  logic             e;
  logic             g;
  logic             busy;
  logic             done;
  logic             pass;
  logic [2*WIDTH:0] err_count;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic [1:0]       fsm_state;

  int   mode;
  logic [2:0] fault_tab [NVEC];

  int n_compared;
  int n_failed;

  comparator_bist #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .l         (l),
    .e         (e),
    .g         (g),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_a    (fail_a),
    .fail_b    (fail_b),
    .fsm_state (fsm_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response {l,e,g} of the comparator under the current fault mode.
  function automatic logic [2:0] resp_of(input int md, input int av, input int bv);
    logic [2:0] good;
    good = {(av < bv), (av == bv), (av > bv)};
    case (md)
      M_E_STUCK: resp_of = {good[2], 1'b0, good[0]};
      M_LG_SWAP: resp_of = {good[0], good[1], good[2]};
      M_ALL_ONE: resp_of = 3'b111;
      M_RANDOM:  resp_of = good ^ fault_tab[av * (1 << WIDTH) + bv];
      default:   resp_of = good;
    endcase
  endfunction

  // Comparator model wired to the BIST operands.
  always_comb begin
    {l, e, g} = resp_of(mode, int'(a), int'(b));
  end

  task automatic apply_reset();
    start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Checks every output is at its reset/idle value.
  task automatic check_idle_outputs(input string name);
    n_compared++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || a !== '0 || b !== '0 ||
        err_count !== '0 || fail_a !== '0 || fail_b !== '0 || fsm_state !== 2'd0) begin
      n_failed++;
      $display("FAIL %s: busy=%b done=%b pass=%b a=%0d b=%0d err=%0d fa=%0d fb=%0d st=%0d, required all 0",
               name, busy, done, pass, a, b, err_count, fail_a, fail_b, fsm_state);
    end
  endtask

  // Starts a run, follows it to completion and checks length, operand
  // sequence and results against the model. A start re-pulse is injected on
  // busy cycle 'poke' (negative: none).
  task automatic run_check(input int md, input int poke, input string name);
    int exp_err;
    int exp_fa;
    int exp_fb;
    bit seen;
    int cyc;
    int seq_bad;
    logic [2:0] good;
    logic [2:0] got;
    exp_err = 0; exp_fa = 0; exp_fb = 0; seen = 0;
    mode = md;
    for (int v = 0; v < NVEC; v++) begin
      int av;
      int bv;
      av = v / (1 << WIDTH);
      bv = v % (1 << WIDTH);
      good = {(av < bv), (av == bv), (av > bv)};
      got  = resp_of(md, av, bv);
      if (got != good) begin
        exp_err++;
        if (!seen) begin
          seen = 1; exp_fa = av; exp_fb = bv;
        end
      end
    end

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_compared++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || err_count !== '0 ||
        fail_a !== '0 || fail_b !== '0) begin
      n_failed++;
      $display("FAIL %s_accept: busy=%b done=%b pass=%b err=%0d fa=%0d fb=%0d, required busy=1 rest 0",
               name, busy, done, pass, err_count, fail_a, fail_b);
    end

    cyc = 0; seq_bad = 0;
    while (busy === 1'b1 && cyc < 4 * RUN_CYCLES) begin
      if (int'(a) != (cyc / SETTLE) / (1 << WIDTH) || int'(b) != (cyc / SETTLE) % (1 << WIDTH))
        seq_bad++;
      start = (cyc == poke) ? 1'b1 : 1'b0;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;

    n_compared++;
    if (cyc != RUN_CYCLES) begin
      n_failed++;
      $display("FAIL %s_length: busy cycles=%0d, required %0d", name, cyc, RUN_CYCLES);
    end
    n_compared++;
    if (seq_bad != 0) begin
      n_failed++;
      $display("FAIL %s_sequence: bad operand cycles=%0d, required 0", name, seq_bad);
    end
    n_compared++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== (exp_err == 0) || a !== '0 || b !== '0) begin
      n_failed++;
      $display("FAIL %s_done: done=%b busy=%b pass=%b a=%0d b=%0d, required done=1 busy=0 pass=%0d a=b=0",
               name, done, busy, pass, a, b, (exp_err == 0));
    end
    n_compared++;
    if (int'(err_count) != exp_err || int'(fail_a) != exp_fa || int'(fail_b) != exp_fb) begin
      n_failed++;
      $display("FAIL %s_result: err=%0d fa=%0d fb=%0d, required err=%0d fa=%0d fb=%0d",
               name, err_count, fail_a, fail_b, exp_err, exp_fa, exp_fb);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_idle_outputs("reset");
    repeat (5) @(negedge clk);
    check_idle_outputs("idle_hold");
  endtask

  task automatic test_good();
    run_check(M_GOOD, -1, "good");
  endtask

  task automatic test_e_stuck();
    run_check(M_E_STUCK, -1, "e_stuck");
  endtask

  task automatic test_lg_swap();
    run_check(M_LG_SWAP, -1, "lg_swap");
  endtask

  task automatic test_all_ones();
    run_check(M_ALL_ONE, -1, "all_ones");
  endtask

  task automatic test_random_faults();
    for (int it = 0; it < 3; it++) begin
      for (int v = 0; v < NVEC; v++) begin
        fault_tab[v] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      end
      run_check(M_RANDOM, -1, $sformatf("random%0d", it));
    end
  endtask

  task automatic test_start_ignored();
    run_check(M_GOOD, 100, "restart_ignored");
  endtask

  // Results must hold in DONE, then clear on a back-to-back start.
  task automatic test_back_to_back();
    logic [2*WIDTH:0] err_snap;
    logic [WIDTH-1:0] fa_snap;
    logic [WIDTH-1:0] fb_snap;
    run_check(M_LG_SWAP, -1, "b2b_first");
    err_snap = err_count; fa_snap = fail_a; fb_snap = fail_b;
    repeat (6) @(negedge clk);
    n_compared++;
    if (err_count !== err_snap || fail_a !== fa_snap || fail_b !== fb_snap ||
        done !== 1'b1 || a !== '0 || b !== '0) begin
      n_failed++;
      $display("FAIL done_hold: err=%0d fa=%0d fb=%0d done=%b a=%0d b=%0d, required err=%0d fa=%0d fb=%0d done=1 a=b=0",
               err_count, fail_a, fail_b, done, a, b, err_snap, fa_snap, fb_snap);
    end
    run_check(M_GOOD, -1, "b2b_second");
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    mode = M_ALL_ONE;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    n_compared++;
    if (busy !== 1'b1 || err_count === '0) begin
      n_failed++;
      $display("FAIL midrun_progress: busy=%b err=%0d, required busy=1 err>0", busy, err_count);
    end
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_idle_outputs("post_reset_idle");
    run_check(M_GOOD, -1, "after_reset");
  endtask

  initial begin
    n_compared = 0;
    n_failed   = 0;
    mode  = M_GOOD;
    start = 1'b0;
    rst_n = 1'b0;
    for (int v = 0; v < NVEC; v++) fault_tab[v] = 3'b000;
    test_reset();
    test_good();
    test_e_stuck();
    test_lg_swap();
    test_all_ones();
    test_random_faults();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/comparator_bist.md
COMPARATOR_BIST -- requirements
Module: comparator_bist

Interface
REQ-001 Parameter WIDTH, default 4: operand width driven to the comparator under test.
REQ-002 Parameter SETTLE, default 2, legal range 1..15: clock cycles each vector is held before the response is sampled.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  run request, sampled on the rising edge.
REQ-006 a  output  WIDTH  operand A driven to the comparator.
REQ-007 b  output  WIDTH  operand B driven to the comparator.
REQ-008 l  input  1  comparator "A less than B" response.
REQ-009 e  input  1  comparator "A equal to B" response.
REQ-010 g  input  1  comparator "A greater than B" response.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  high from run completion until the next accepted start.
REQ-013 pass  output  1  valid while done is high; 1 means zero mismatches.
REQ-014 err_count  output  2*WIDTH+1  number of mismatching vectors in the current or last run.
REQ-015 fail_a  output  WIDTH  operand A of the first mismatching vector.
REQ-016 fail_b  output  WIDTH  operand B of the first mismatching vector.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1.
- DONE -> RUN on start=1.
- RUN -> DONE after the last vector is sampled.
- All other conditions hold the current state.
REQ-018 start while in RUN shall be ignored; the run shall not restart and counters shall not clear.
REQ-019 Accepting start shall have these effects on the next edge:
- vector index idx set to 0;
- err_count and the first-fail flag cleared;
- fail_a and fail_b set to 0;
- done=0, busy=1.
REQ-020 Vector mapping: a = idx[2*WIDTH-1:WIDTH], b = idx[WIDTH-1:0]; idx runs 0 to 2^(2*WIDTH)-1 in ascending order, with b incrementing fastest.
REQ-021 Hold and sample:
- each vector is held on a/b for exactly SETTLE cycles;
- l/e/g are sampled on the edge that ends the SETTLE-th cycle;
- idx increments on that same edge.
REQ-022 Expected response is one-hot:
- l=1 iff a<b (unsigned);
- e=1 iff a==b;
- g=1 iff a>b.
Any deviation in any bit, including non-one-hot responses, is a mismatch.
REQ-023 Each mismatching vector shall increment err_count by 1; err_count saturates at its maximum value and never wraps.
REQ-024 On the first mismatch of a run only, fail_a/fail_b capture that vector's a/b; later mismatches leave them unchanged.
REQ-025 Run timing:
- a full run lasts exactly 2^(2*WIDTH)*SETTLE cycles in RUN;
- busy falls and done rises on the edge that samples the last vector;
- there is no extra cycle between the last sample and done.
REQ-026 pass shall equal (err_count==0) while done=1; pass shall be 0 in IDLE and RUN.
REQ-027 a and b shall be 0 in IDLE and DONE.
REQ-028 err_count, fail_a and fail_b shall hold their values in DONE until the next accepted start.

Reset
REQ-029 rst_n=0 shall immediately force, without waiting for a clock edge:
- state=IDLE;
- idx=0 and the settle counter =0;
- a=0, b=0;
- busy=0, done=0, pass=0;
- err_count=0, fail_a=0, fail_b=0.
REQ-030 Reset asserted mid-run shall abort the run with no partial result retained.
REQ-031 After rst_n rises, the block shall stay in IDLE until start is seen.

Verification
REQ-032 Correct comparator model, WIDTH=4, SETTLE=2, start pulse -> busy for exactly 512 cycles; then done=1, pass=1, err_count=0.
REQ-033 e stuck at 0, l/g correct -> err_count=16, fail_a=0, fail_b=0, pass=0.
REQ-034 l and g swapped, e correct -> err_count=240, fail_a=0, fail_b=1.
REQ-035 l=e=g=1 constant -> err_count=256, fail_a=0, fail_b=0.
REQ-036 Pulse start again at cycle 100 of a run -> ignored; done still arrives 512 cycles after the original start.
REQ-037 Assert rst_n=0 at cycle 300 of a run, then restart -> all outputs 0 immediately; the new run reports pass=1 with the correct model.
